// File: rtl/cop0_pkg.sv
// Shared COP0 definitions: interrupt sequencer state encoding, COP0 register
// addresses, the default exception vector and the restart-PC selection helper.
package cop0_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_TAKE  = 3'd2,
        ST_ERET  = 3'd3,
        ST_FLUSH = 3'd4
    } seq_state_t;

    localparam logic [4:0] COP0_REG_COUNT   = 5'h9;
    localparam logic [4:0] COP0_REG_COMPARE = 5'hB;
    localparam logic [4:0] COP0_REG_STATUS  = 5'hC;
    localparam logic [4:0] COP0_REG_CAUSE   = 5'hD;
    localparam logic [4:0] COP0_REG_EPC     = 5'hE;

    localparam logic [31:0] DEFAULT_HANDLER_VECTOR = 32'hC000_0180;

    // A delay-slot instruction must restart at its branch, or the branch is lost.
    function automatic logic [31:0] select_restart_pc(
        input logic        in_branch_delay,
        input logic [31:0] branch_pc,
        input logic [31:0] instr_pc
    );
        return in_branch_delay ? branch_pc : instr_pc;
    endfunction

endpackage

// File: rtl/interrupt_sequencer.sv
// CPU-side interrupt/ERET sequencer: waits for a safe execute-stage boundary,
// captures the restart PC, redirects fetch and squashes younger stages.
module interrupt_sequencer
    import cop0_pkg::*;
#(
    parameter logic [31:0] HANDLER_VECTOR = DEFAULT_HANDLER_VECTOR,
    parameter int unsigned FLUSH_CYCLES   = 2
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic        Enable,
    input  logic        InterruptRequest,
    input  logic        InstrValid,
    input  logic [31:0] InstrPC,
    input  logic        InBranchDelay,
    input  logic [31:0] BranchPC,
    input  logic        MemBusy,
    input  logic        EretDecoded,
    input  logic [31:0] EPC,
    output logic [31:0] InterruptedPC,
    output logic        InterruptHandled,
    output logic        Redirect,
    output logic [31:0] RedirectPC,
    output logic        Flush,
    output logic        EretDone
);

    localparam int unsigned           CNT_W      = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CNT_W-1:0]      FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);

    seq_state_t        state;
    logic [CNT_W-1:0]  flush_count;
    logic [31:0]       interrupted_pc_q;
    logic [31:0]       redirect_pc_q;
    logic              handled_q;
    logic              redirect_q;
    logic              eret_done_q;
    logic              flush_q;

    logic              safe;
    logic [31:0]       restart_pc;

    assign safe       = InstrValid & ~MemBusy;
    assign restart_pc = select_restart_pc(InBranchDelay, BranchPC, InstrPC);

    // All outputs are registered alongside the state they belong to; a stall
    // freezes everything, so a pending pulse survives until the pipeline moves.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state            <= ST_IDLE;
            flush_count      <= '0;
            interrupted_pc_q <= '0;
            redirect_pc_q    <= '0;
            handled_q        <= 1'b0;
            redirect_q       <= 1'b0;
            eret_done_q      <= 1'b0;
            flush_q          <= 1'b0;
        end else if (Enable) begin
            handled_q   <= 1'b0;
            redirect_q  <= 1'b0;
            eret_done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (EretDecoded && safe) begin
                        state         <= ST_ERET;
                        redirect_pc_q <= EPC;
                        redirect_q    <= 1'b1;
                        eret_done_q   <= 1'b1;
                        flush_q       <= 1'b1;
                    end else if (InterruptRequest && safe) begin
                        state            <= ST_TAKE;
                        interrupted_pc_q <= restart_pc;
                        redirect_pc_q    <= HANDLER_VECTOR;
                        handled_q        <= 1'b1;
                        redirect_q       <= 1'b1;
                        flush_q          <= 1'b1;
                    end else if (InterruptRequest) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!InterruptRequest) begin
                        state <= ST_IDLE;
                    end else if (safe) begin
                        state            <= ST_TAKE;
                        interrupted_pc_q <= restart_pc;
                        redirect_pc_q    <= HANDLER_VECTOR;
                        handled_q        <= 1'b1;
                        redirect_q       <= 1'b1;
                        flush_q          <= 1'b1;
                    end
                end
                ST_TAKE, ST_ERET: begin
                    if (FLUSH_LOAD == '0) begin
                        state   <= ST_IDLE;
                        flush_q <= 1'b0;
                    end else begin
                        state       <= ST_FLUSH;
                        flush_count <= FLUSH_LOAD;
                    end
                end
                ST_FLUSH: begin
                    // Counter stops at zero; the last flush cycle is the one seeing 1.
                    if (flush_count <= CNT_ONE) begin
                        state       <= ST_IDLE;
                        flush_count <= '0;
                        flush_q     <= 1'b0;
                    end else begin
                        flush_count <= flush_count - CNT_ONE;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    flush_count <= '0;
                    flush_q     <= 1'b0;
                end
            endcase
        end
    end

    // Stalled cycles must not be seen downstream as a second pulse.
    assign InterruptHandled = handled_q & Enable;
    assign Redirect         = redirect_q & Enable;
    assign EretDone         = eret_done_q & Enable;
    assign Flush            = flush_q;
    assign InterruptedPC    = interrupted_pc_q;
    assign RedirectPC       = redirect_pc_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed self-checking bench for interrupt_sequencer: entry, delay-slot
// restart, memory wait, request withdrawal, ERET tie-break, stall and reset.
module tb_interrupt_sequencer;

    logic        Clock;
    logic        Reset_n;
    logic        Enable;
    logic        InterruptRequest;
    logic        InstrValid;
    logic [31:0] InstrPC;
    logic        InBranchDelay;
    logic [31:0] BranchPC;
    logic        MemBusy;
    logic        EretDecoded;
    logic [31:0] EPC;
    logic [31:0] InterruptedPC;
    logic        InterruptHandled;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic        Flush;
    logic        EretDone;

    int num_asserts;
    int num_failures;

    localparam logic [31:0] VEC = 32'hC000_0180;

    interrupt_sequencer dut (
        .Clock            (Clock),
        .Reset_n          (Reset_n),
        .Enable           (Enable),
        .InterruptRequest (InterruptRequest),
        .InstrValid       (InstrValid),
        .InstrPC          (InstrPC),
        .InBranchDelay    (InBranchDelay),
        .BranchPC         (BranchPC),
        .MemBusy          (MemBusy),
        .EretDecoded      (EretDecoded),
        .EPC              (EPC),
        .InterruptedPC    (InterruptedPC),
        .InterruptHandled (InterruptHandled),
        .Redirect         (Redirect),
        .RedirectPC       (RedirectPC),
        .Flush            (Flush),
        .EretDone         (EretDone)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic applyStimulus(
        input logic        req,
        input logic        valid,
        input logic [31:0] pc,
        input logic        in_delay,
        input logic [31:0] branch_pc,
        input logic        busy,
        input logic        eret,
        input logic [31:0] epc
    );
        InterruptRequest = req;
        InstrValid       = valid;
        InstrPC          = pc;
        InBranchDelay    = in_delay;
        BranchPC         = branch_pc;
        MemBusy          = busy;
        EretDecoded      = eret;
        EPC              = epc;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        num_asserts++;
        assert (observed === expected) else begin
            num_failures++;
            $error("[TB] FAIL %s: got %08h, required %08h", tag, observed, expected);
        end
    endtask

    task automatic checkOutputBit(input string tag, input logic observed, input logic expected);
        num_asserts++;
        assert (observed === expected) else begin
            num_failures++;
            $error("[TB] FAIL %s: got %b, required %b", tag, observed, expected);
        end
    endtask

    task automatic checkPulses(input string tag, input logic handled, input logic redirect,
                               input logic eret_done, input logic flush);
        checkOutputBit({tag, ".handled"},  InterruptHandled, handled);
        checkOutputBit({tag, ".redirect"}, Redirect,         redirect);
        checkOutputBit({tag, ".eretdone"}, EretDone,         eret_done);
        checkOutputBit({tag, ".flush"},    Flush,            flush);
    endtask

    initial begin
        num_asserts  = 0;
        num_failures = 0;
        Reset_n      = 1'b0;
        Enable       = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

        tick();
        tick();
        checkPulses("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset.intpc",   InterruptedPC, 32'h0);
        checkOutput("reset.redirpc", RedirectPC,    32'h0);
        Reset_n = 1'b1;
        tick();
        checkPulses("idle", 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] basic interrupt entry");
        applyStimulus(1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        checkPulses("t1.take", 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("t1.intpc",   InterruptedPC, 32'h100);
        checkOutput("t1.redirpc", RedirectPC,    VEC);
        applyStimulus(1'b0, 1'b0, 32'h104, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        checkPulses("t1.flush", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        checkPulses("t1.idle", 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] delay-slot restart");
        applyStimulus(1'b1, 1'b1, 32'h204, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0);
        tick();
        checkPulses("t2.take", 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("t2.intpc", InterruptedPC, 32'h200);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        checkPulses("t2.idle", 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] wait on memory busy");
        applyStimulus(1'b1, 1'b1, 32'h400, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkPulses("t3.wait", 1'b0, 1'b0, 1'b0, 1'b0);
        end
        MemBusy = 1'b0;
        tick();
        checkPulses("t3.take", 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("t3.intpc", InterruptedPC, 32'h400);
        InterruptRequest = 1'b0;
        tick();
        checkPulses("t3.flush", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        checkPulses("t3.idle", 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] request withdrawn while waiting");
        applyStimulus(1'b1, 1'b1, 32'h480, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        tick();
        checkPulses("t4.wait", 1'b0, 1'b0, 1'b0, 1'b0);
        InterruptRequest = 1'b0;
        tick();
        checkPulses("t4.drop", 1'b0, 1'b0, 1'b0, 1'b0);
        MemBusy = 1'b0;
        tick();
        checkPulses("t4.idle", 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] eret wins tie, then back-to-back request");
        applyStimulus(1'b1, 1'b1, 32'h600, 1'b0, 32'h0, 1'b0, 1'b1, 32'h300);
        tick();
        checkPulses("t5.eret", 1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("t5.redirpc", RedirectPC, 32'h300);
        EretDecoded = 1'b0;
        tick();
        checkPulses("t5.flush", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        checkPulses("t5.idle", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkPulses("t5.retake", 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("t5.intpc",   InterruptedPC, 32'h600);
        checkOutput("t5.vecpc",   RedirectPC,    VEC);
        InterruptRequest = 1'b0;
        tick();
        tick();
        checkPulses("t5.end", 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] stall during take, reset during flush");
        applyStimulus(1'b1, 1'b1, 32'h500, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        Enable  = 1'b0;
        InstrPC = 32'h700;
        #1;
        checkPulses("t6.stall0", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        checkPulses("t6.stall2", 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("t6.intpc", InterruptedPC, 32'h500);
        Enable = 1'b1;
        #1;
        checkPulses("t6.release", 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        checkPulses("t6.flush", 1'b0, 1'b0, 1'b0, 1'b1);
        #2;
        Reset_n = 1'b0;
        #1;
        checkPulses("t6.reset", 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t6.rst.intpc",   InterruptedPC, 32'h0);
        checkOutput("t6.rst.redirpc", RedirectPC,    32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        Reset_n = 1'b1;
        tick();
        checkPulses("t6.after", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkPulses("t6.after2", 1'b0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", num_asserts, num_failures);
        $finish;
    end

endmodule
